kyber_decrypt: RTL and testbench
================================

Name: kyber_decrypt

Overview:
- Baby Kyber decryption core (K=2, N=4, q=17) in Z17[x]/(x^4+1), the receive side of the encryption datapath.
- Takes ciphertext (u, v) and secret key s, computes w = v − sᵀ·u mod 17, and decodes each coefficient of w into one message bit.
- Uses one serial multiply-accumulate engine driven by an FSM, with a start/busy/done handshake.
- Sits beside the encrypt block; its ciphertext ports match the encrypt ciphertext layout.

Parameters:
- Q, 17, modulus.
- N, 4, coefficients per polynomial; reduction polynomial x^N+1.
- K, 2, module rank (polynomials in u and s).
- COEFF_W, 32, signed input coefficient width.
- Only the defaults are verified; MAC_CYCLES = K*N*N = 32.

Ports:
- clk  input  1  clock; reset rst_n, asynchronous, active-low; clock clk.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- ct_u  input  signed COEFF_W, unpacked [K-1:0][N-1:0]  ciphertext u.
- ct_v  input  signed COEFF_W, unpacked [N-1:0]  ciphertext v.
- secret_key  input  signed COEFF_W, unpacked [K-1:0][N-1:0]  secret s.
- message  output  N  decoded bits; bit i comes from w coefficient i.
- busy  output  1  high while a decrypt is in progress.
- done  output  1  one-cycle pulse when message is valid.

Behaviour:
- Reset (async): state=IDLE, message=0, busy=0, done=0, accumulators=0, counters=0.
- States: IDLE → MAC → FINISH → IDLE. busy = (state != IDLE), registered.
- IDLE:
  - On a clock edge with start=1 (edge T0), latch ct_u, ct_v and secret_key into internal registers.
  - Normalize every coefficient on capture to [0,Q−1] by floored mod: r = x%Q; if r<0 then r += Q.
  - Clear acc[0..N-1] and go to MAC.
  - Inputs may change freely after T0.
- MAC: one product per edge, edges T1..T32.
  - Index order: p outer (0..K-1), i middle (0..N-1), j inner (0..N-1).
  - k=(i+j) mod N; prod = s[p][i]*u[p][j] (0..256).
  - If i+j<N: acc[k] = (acc[k]+prod) mod Q. Otherwise (negacyclic wrap): acc[k] = (acc[k]−prod) mod Q.
  - Result is always kept in [0,Q−1].
  - Leave MAC on the edge that performs the last product (T32) → FINISH.
- FINISH (edge T33), all N coefficients in parallel:
  - w_k = (v_k − acc_k) mod Q, in [0,Q−1].
  - message[k] = 1 iff Q/4 < w_k < Q − Q/4 (integer division), i.e. 5 ≤ w_k ≤ 12; else 0.
  - Register message, set done=1, go to IDLE.
- done is high for exactly one cycle (after T33); it is cleared on the next edge unless a new result completes.
- Latency: start edge T0 → done high after edge T33 (33 cycles). busy is high after T0 through T32 and low in the done cycle.
- message holds its value until the next FINISH or reset. It is not cleared on a new start.
- start while busy is ignored; the in-flight operation is unaffected.
- start=1 in the done cycle (state IDLE) is accepted: back-to-back throughput is one result per 34 cycles.
- Reset mid-operation: immediate return to the reset values; no done pulse for the aborted operation.
- Arithmetic: the product fits in 9 bits; acc±prod fits in a signed 10-bit intermediate. No overflow is possible after normalization.

Test Plan:
- s=0, u=0, v={0,9,8,13} → done exactly 33 cycles after the start edge; message=4'b0110; busy high for 33 cycles.
- s0={1,0,0,0}, s1=0, u0={1,2,3,4}, u1=0, v={10,11,12,13} → w={9,9,9,9}, message=4'b1111.
- Negacyclic wrap: s0={0,1,0,0}, u0={0,0,0,9}, s1=u1=0, v=0 → acc0=−9≡8, w0=9, message=4'b0001.
- Input normalization: s=0, v={−8,−17,26,−1} → w={9,0,9,16}, message=4'b0101.
- Ignore/abort:
  - Pulse start again at cycle 5 of busy → a single done at cycle 33, result unchanged.
  - Then assert rst_n=0 at MAC cycle 10 → busy=0, done=0, message=0 immediately, and no done follows.
  - A fresh start after reset yields the correct result.
- Back-to-back: start asserted in the done cycle with new operands → accepted; second done 34 cycles after the first with the second message; message is stable in between.

Source files
------------

// File: rtl/kyber_decrypt_if.sv
// Decrypt request/result bundle: ciphertext and key in, decoded message and handshake out.
interface kyber_decrypt_if #(
  parameter int K       = 2,
  parameter int N       = 4,
  parameter int COEFF_W = 32
);
  logic                      start;
  logic signed [COEFF_W-1:0] ct_u       [K-1:0][N-1:0];
  logic signed [COEFF_W-1:0] ct_v       [N-1:0];
  logic signed [COEFF_W-1:0] secret_key [K-1:0][N-1:0];
  logic [N-1:0]              message;
  logic                      busy;
  logic                      done;

  modport master (output start, ct_u, ct_v, secret_key, input message, busy, done);
  modport slave  (input start, ct_u, ct_v, secret_key, output message, busy, done);
endinterface

// File: rtl/kyber_decrypt.sv
// Baby Kyber decryption: w = v - s^T*u in Z17[x]/(x^4+1) with one serial MAC,
// then each coefficient of w is thresholded into one message bit.
module kyber_decrypt #(
  parameter int Q       = 17,
  parameter int N       = 4,
  parameter int K       = 2,
  parameter int COEFF_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  kyber_decrypt_if.slave   bus
);
  localparam int RW         = $clog2(Q);
  localparam int IW         = $clog2(N);
  localparam int PW         = $clog2(K);
  localparam int CW         = PW + 2 * IW;
  localparam int SW         = 2 * RW + 2;
  localparam int MAC_CYCLES = K * N * N;
  localparam int Q4         = Q / 4;

  typedef enum logic [1:0] {IDLE, MAC, FINISH} state_t;

  state_t          state_reg, state_next;
  logic [RW-1:0]   u_reg   [K][N];
  logic [RW-1:0]   s_reg   [K][N];
  logic [RW-1:0]   v_reg   [N];
  logic [RW-1:0]   acc_reg [N];
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    message_reg;
  logic            busy_reg;
  logic            done_reg;

  // Floored mod of a raw input coefficient into [0,Q-1].
  function automatic logic [RW-1:0] norm_in(input logic signed [COEFF_W-1:0] x);
    logic signed [COEFF_W-1:0] r;
    r = x % COEFF_W'(Q);
    if (r < 0) r = r + COEFF_W'(Q);
    return RW'(r);
  endfunction

  function automatic logic [RW-1:0] mod_q(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    r = x % SW'(Q);
    if (r < 0) r = r + SW'(Q);
    return RW'(r);
  endfunction

  // Counter bits map directly onto the p (outer), i, j (inner) loop order.
  logic [PW-1:0]      p_idx;
  logic [IW-1:0]      i_idx, j_idx, k_idx;
  logic [IW:0]        ij_sum;
  logic               wrap;
  logic [2*RW-1:0]    prod;
  logic signed [SW-1:0] acc_ext, prod_ext, mac_sum;

  assign p_idx    = cnt_reg[CW-1 -: PW];
  assign i_idx    = cnt_reg[2*IW-1 -: IW];
  assign j_idx    = cnt_reg[IW-1:0];
  assign ij_sum   = {1'b0, i_idx} + {1'b0, j_idx};
  assign wrap     = ij_sum[IW];
  assign k_idx    = ij_sum[IW-1:0];
  assign prod     = {{RW{1'b0}}, s_reg[p_idx][i_idx]} * {{RW{1'b0}}, u_reg[p_idx][j_idx]};
  assign acc_ext  = $signed(SW'(acc_reg[k_idx]));
  assign prod_ext = $signed(SW'(prod));
  assign mac_sum  = wrap ? (acc_ext - prod_ext) : (acc_ext + prod_ext);

  logic [N-1:0] decoded;
  for (genvar gi = 0; gi < N; gi++) begin : g_decode
    logic [RW-1:0] w;
    assign w = mod_q($signed(SW'(v_reg[gi])) - $signed(SW'(acc_reg[gi])));
    assign decoded[gi] = (w > RW'(Q4)) && (w < RW'(Q - Q4));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = MAC;
      MAC:     if (cnt_reg == CW'(MAC_CYCLES - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_reg == FINISH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      message_reg <= '0;
      for (int p = 0; p < K; p++)
        for (int n = 0; n < N; n++) begin
          u_reg[p][n] <= '0;
          s_reg[p][n] <= '0;
        end
      for (int n = 0; n < N; n++) begin
        v_reg[n]   <= '0;
        acc_reg[n] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: if (bus.start) begin
          cnt_reg <= '0;
          for (int p = 0; p < K; p++)
            for (int n = 0; n < N; n++) begin
              u_reg[p][n] <= norm_in(bus.ct_u[p][n]);
              s_reg[p][n] <= norm_in(bus.secret_key[p][n]);
            end
          for (int n = 0; n < N; n++) begin
            v_reg[n]   <= norm_in(bus.ct_v[n]);
            acc_reg[n] <= '0;
          end
        end
        MAC: begin
          acc_reg[k_idx] <= mod_q(mac_sum);
          cnt_reg        <= cnt_reg + 1'b1;
        end
        FINISH:  message_reg <= decoded;
        default: ;
      endcase
    end
  end

  assign bus.message = message_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
endmodule

// File: tb/tb_kyber_decrypt.sv
// Directed vector bench for kyber_decrypt: table of operands/messages plus
// ignore-while-busy, mid-operation reset and back-to-back sequences.
module tb_kyber_decrypt;
  localparam int K = 2;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kyber_decrypt_if #(.K(K), .N(N), .COEFF_W(W)) bus ();
  kyber_decrypt #(.Q(17), .N(N), .K(K), .COEFF_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef logic [3:0][31:0] poly_t;
  typedef struct {
    poly_t s0, s1, u0, u1, v;
    logic [3:0] msg;
  } vec_t;

  vec_t tbl [7];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic poly_t mk(input int a0, input int a1, input int a2, input int a3);
    poly_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_op(input int idx);
    for (int n = 0; n < N; n++) begin
      bus.secret_key[0][n] = tbl[idx].s0[n];
      bus.secret_key[1][n] = tbl[idx].s1[n];
      bus.ct_u[0][n]       = tbl[idx].u0[n];
      bus.ct_u[1][n]       = tbl[idx].u1[n];
      bus.ct_v[n]          = tbl[idx].v[n];
    end
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    // Operands must have been latched at the start edge.
    for (int n = 0; n < N; n++) begin
      bus.secret_key[0][n] = $urandom;
      bus.secret_key[1][n] = $urandom;
      bus.ct_u[0][n]       = $urandom;
      bus.ct_u[1][n]       = $urandom;
      bus.ct_v[n]          = $urandom;
    end
  endtask

  task automatic wait_done(input int idx, input int poke, input int rst_at,
                           input logic [3:0] prev, input bit drop_chk);
    int cyc = 0;
    int busy_n = 0;
    int unstable = 0;
    int late_done = 0;
    int late_busy = 0;
    bit aborted = 1'b0;
    while (!bus.done && cyc < 100) begin
      if (cyc == rst_at) begin
        aborted = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
      if (bus.message !== prev) unstable++;
      bus.start = (cyc == poke);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check($sformatf("abort_busy v%0d", idx), 32'(bus.busy), 32'd0);
      check($sformatf("abort_done v%0d", idx), 32'(bus.done), 32'd0);
      check($sformatf("abort_msg v%0d", idx), 32'(bus.message), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (bus.done) late_done++;
        if (bus.busy) late_busy++;
      end
      check("abort_no_done", late_done, 0);
      check("abort_no_busy", late_busy, 0);
      $display("vec %0d aborted by reset at cycle %0d", idx, rst_at);
    end else begin
      check($sformatf("latency v%0d", idx), cyc, 33);
      check($sformatf("busy_cycles v%0d", idx), busy_n, 33);
      check($sformatf("busy_low_at_done v%0d", idx), 32'(bus.busy), 32'd0);
      check($sformatf("msg_stable v%0d", idx), unstable, 0);
      check($sformatf("message v%0d", idx), 32'(bus.message), 32'(tbl[idx].msg));
      $display("vec %0d: message=%b latency=%0d", idx, bus.message, cyc);
      if (drop_chk) begin
        @(negedge clk);
        check($sformatf("done_pulse v%0d", idx), 32'(bus.done), 32'd0);
      end
    end
  endtask

  initial begin
    tbl[0] = '{mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(0,9,8,13), 4'b0110};
    tbl[1] = '{mk(1,0,0,0), mk(0,0,0,0), mk(1,2,3,4), mk(0,0,0,0), mk(10,11,12,13), 4'b1111};
    tbl[2] = '{mk(0,1,0,0), mk(0,0,0,0), mk(0,0,0,9), mk(0,0,0,0), mk(0,0,0,0), 4'b0001};
    tbl[3] = '{mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(-8,-17,26,-1), 4'b0101};
    tbl[4] = '{mk(2,0,0,0), mk(0,0,0,1), mk(3,1,0,0), mk(1,0,0,0), mk(0,0,0,0), 4'b0001};
    tbl[5] = '{mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(4,5,12,13), 4'b0110};
    tbl[6] = '{mk(-1,16,-18,33), mk(0,0,1,0), mk(16,0,0,0), mk(0,0,3,0), mk(3,6,6,6), 4'b1111};

    bus.start = 1'b0;
    for (int p = 0; p < K; p++)
      for (int n = 0; n < N; n++) begin
        bus.ct_u[p][n]       = '0;
        bus.secret_key[p][n] = '0;
      end
    for (int n = 0; n < N; n++) bus.ct_v[n] = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_msg", 32'(bus.message), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      start_op(v);
      wait_done(v, -1, -1, (v == 0) ? 4'b0000 : tbl[v-1].msg, 1'b1);
    end

    // start re-pulsed while busy must be ignored
    start_op(0);
    wait_done(0, 5, -1, tbl[6].msg, 1'b1);

    // reset at MAC cycle 10, then a fresh operation
    start_op(1);
    wait_done(1, -1, 10, tbl[0].msg, 1'b0);
    start_op(2);
    wait_done(2, -1, -1, 4'b0000, 1'b1);

    // back-to-back: second start issued in the done cycle
    start_op(3);
    wait_done(3, -1, -1, tbl[2].msg, 1'b0);
    start_op(4);
    wait_done(4, -1, -1, tbl[3].msg, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
